cs42448_dac: RTL

CS42448_DAC -- requirements
Module: cs42448_dac

---
 rtl/cs42448_dac.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cs42448_dac.sv
// Four-line serial DAC feeder for the CS42448: 64-cycle frames with 32 SCLK periods,
// a single 8-word holding buffer, and a gated startup delay after codec init.
`timescale 1ns/1ps
module cs42448_dac #(
    parameter int unsigned STARTUP_FRAMES = 18750
) (
    input  logic        sys_clk,
    input  logic        sys_nrst,
    input  logic        init_done,
    input  logic [15:0] dac_din_l0,
    input  logic [15:0] dac_din_l1,
    input  logic [15:0] dac_din_l2,
    input  logic [15:0] dac_din_l3,
    input  logic [15:0] dac_din_r0,
    input  logic [15:0] dac_din_r1,
    input  logic [15:0] dac_din_r2,
    input  logic [15:0] dac_din_r3,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        frame_strb,
    output logic        underrun,
    output logic        dac_run,
    output logic        DAC_SDOUT_CH0,
    output logic        DAC_SDOUT_CH1,
    output logic        DAC_SDOUT_CH2,
    output logic        DAC_SDOUT_CH3,
    output logic        DAC_SCLK,
    output logic        DAC_LRCK
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [5:0]       r_div;
    logic [15:0]      r_frame_cnt;
    logic             r_full;
    logic [3:0][15:0] r_hold_l;
    logic [3:0][15:0] r_hold_r;
    logic [3:0][15:0] r_act_l;
    logic [3:0][15:0] r_act_r;
    logic             r_frame_strb;
    logic             r_underrun;
    logic             r_sclk;
    logic             r_lrck;
    logic [3:0]       r_sdout;

    logic [3:0][15:0] w_din_l;
    logic [3:0][15:0] w_din_r;
    logic             w_frame_end;
    logic             w_last_startup;
    logic             w_load;
    logic             w_accept;
    logic [3:0]       w_bit_idx;

    assign w_din_l        = {dac_din_l3, dac_din_l2, dac_din_l1, dac_din_l0};
    assign w_din_r        = {dac_din_r3, dac_din_r2, dac_din_r1, dac_din_r0};
    assign w_frame_end    = (r_div == 6'd63);
    assign w_last_startup = (r_frame_cnt == 16'(STARTUP_FRAMES - 1));
    // Slot d[4:1] selects bit 15-d[4:1], i.e. MSB first within each half-frame.
    assign w_bit_idx      = ~r_div[4:1];

    always_comb begin
        // NOTE: default assignment first so every path drives w_next_state and no latch is inferred.
        w_next_state = r_state;
        if (!init_done) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_next_state = ST_WAIT;
                ST_WAIT: if (w_frame_end && w_last_startup) w_next_state = ST_RUN;
                ST_RUN:  w_next_state = ST_RUN;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Loads never coincide with captures: din_ready is held low on the div=63 cycle.
    assign w_load    = w_frame_end && (w_next_state == ST_RUN);
    assign din_ready = ((r_state == ST_WAIT) || (r_state == ST_RUN)) && !r_full && !w_frame_end;
    assign w_accept  = din_valid && din_ready;
    assign dac_run   = (r_state == ST_RUN);

    // NOTE: the sample buffers are flops rather than a RAM, so they can take the async reset.
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            r_state      <= ST_IDLE;
            r_div        <= '0;
            r_frame_cnt  <= '0;
            r_full       <= 1'b0;
            r_hold_l     <= '0;
            r_hold_r     <= '0;
            r_act_l      <= '0;
            r_act_r      <= '0;
            r_frame_strb <= 1'b0;
            r_underrun   <= 1'b0;
            r_sclk       <= 1'b0;
            r_lrck       <= 1'b0;
            r_sdout      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees this cycle's values.
            r_div        <= r_div + 6'd1;
            r_state      <= w_next_state;
            r_frame_strb <= w_load;
            r_underrun   <= w_load && !r_full;

            if (w_next_state == ST_IDLE) begin
                r_frame_cnt <= '0;
                r_full      <= 1'b0;
                r_act_l     <= '0;
                r_act_r     <= '0;
            end else begin
                if ((r_state == ST_WAIT) && w_frame_end) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
                if (w_accept) begin
                    r_hold_l <= w_din_l;
                    r_hold_r <= w_din_r;
                    r_full   <= 1'b1;
                end
                if (w_load) begin
                    r_act_l <= r_full ? r_hold_l : '0;
                    r_act_r <= r_full ? r_hold_r : '0;
                    r_full  <= 1'b0;
                end
            end

            if (r_state == ST_RUN) begin
                r_sclk <= r_div[0];
                r_lrck <= r_div[5];
                for (int n = 0; n < 4; n++) begin
                    r_sdout[n] <= r_div[5] ? r_act_r[n][w_bit_idx] : r_act_l[n][w_bit_idx];
                end
            end else begin
                r_sclk  <= 1'b0;
                r_lrck  <= 1'b0;
                r_sdout <= '0;
            end
        end
    end

    assign frame_strb    = r_frame_strb;
    assign underrun      = r_underrun;
    assign DAC_SCLK      = r_sclk;
    assign DAC_LRCK      = r_lrck;
    assign DAC_SDOUT_CH0 = r_sdout[0];
    assign DAC_SDOUT_CH1 = r_sdout[1];
    assign DAC_SDOUT_CH2 = r_sdout[2];
    assign DAC_SDOUT_CH3 = r_sdout[3];

endmodule
